// File: rtl/ssp_tx_pkg.sv
// Shared types and constants for the SSP serial shift engine.
package ssp_tx_pkg;

    localparam int DW_DEF   = 16;
    localparam int DIVW_DEF = 8;
    localparam int DSSW     = 4;
    localparam int NBW      = 5;   // holds frame lengths up to 16

    localparam logic [DSSW-1:0] MIN_DSS = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL
    } ssp_state_e;

    // Frame length in bits; DSS codes below 3 are widened to a 4-bit frame.
    function automatic logic [NBW-1:0] effective_bits(input logic [DSSW-1:0] dss);
        logic [DSSW-1:0] d;
        d = (dss < MIN_DSS) ? MIN_DSS : dss;
        return {1'b0, d} + NBW'(1);
    endfunction

endpackage

// File: rtl/ssp_sck_divider.sv
// Half-period down-counter: reloaded on each state entry, tc marks the last cycle.
module ssp_sck_divider #(
    parameter int DIVW = 8
) (
    input  logic            SSPCLK,
    input  logic            SSPRST,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    output logic [DIVW-1:0] cnt,
    output logic            tc
);

    always_ff @(posedge SSPCLK or posedge SSPRST) begin
        if (SSPRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DIVW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ssp_tx_serializer.sv
// Motorola SPI master shift engine: pulls words from the TX FIFO head,
// shifts them out MSB first and returns the frame sampled on SSPRXD.
module ssp_tx_serializer
    import ssp_tx_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int DIVW = DIVW_DEF
) (
    input  logic              SSPCLK,
    input  logic              SSPRST,
    input  logic              SSE,
    input  logic              SPO,
    input  logic [DSSW-1:0]   DSS,
    input  logic [DIVW-1:0]   ClkDiv,
    input  logic              TxDataAvlbl,
    input  logic [DW-1:0]     TxData,
    input  logic              SSPRXD,
    output logic              TxFRdPtrInc,
    output logic              SSPCLKOUT,
    output logic              SSPTXD,
    output logic              SSPFSSOUT,
    output logic [DW-1:0]     RxData,
    output logic              RxWrEn,
    output logic              TxRxBSY
);

    localparam int BCW = $clog2(DW);

    ssp_state_e      state_q, state_d;
    logic [DW-2:0]   tx_sr;      // bits still to send after the one on SSPTXD
    logic [DW-1:0]   rx_sr, rx_next;
    logic [BCW-1:0]  bitcnt;
    logic [NBW-1:0]  n_q;
    logic [DIVW-1:0] clkdiv_q;
    logic [DIVW-1:0] hcnt, div_val;
    logic            div_load, tc;
    logic            sck_ph;
    logic            start, lead_first, last_bit;

    assign start      = (state_q == IDLE) && SSE && TxDataAvlbl;
    assign lead_first = (state_q == LEAD) && (hcnt == clkdiv_q);
    assign last_bit   = (NBW'(bitcnt) == (n_q - NBW'(1)));
    assign rx_next    = lead_first ? {rx_sr[DW-2:0], SSPRXD} : rx_sr;

    // IDLE reloads every cycle from the live ClkDiv so SETUP is exact at load.
    assign div_load = (state_q == IDLE) || tc;
    assign div_val  = (state_q == IDLE) ? ClkDiv : clkdiv_q;

    ssp_sck_divider #(.DIVW(DIVW)) u_div (
        .SSPCLK   (SSPCLK),
        .SSPRST   (SSPRST),
        .load     (div_load),
        .load_val (div_val),
        .cnt      (hcnt),
        .tc       (tc)
    );

    // SCK is kept as a registered phase; SPO is static configuration, so the
    // idle level tracks it directly, including while reset is held.
    assign SSPCLKOUT = sck_ph ^ SPO;

    always_ff @(posedge SSPCLK or posedge SSPRST) begin
        if (SSPRST) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (tc)    state_d = LEAD;
            LEAD:    if (tc)    state_d = TRAIL;
            TRAIL:   if (tc)    state_d = last_bit ? IDLE : LEAD;
            default:            state_d = IDLE;
        endcase
    end

    always_ff @(posedge SSPCLK or posedge SSPRST) begin
        if (SSPRST) begin
            TxFRdPtrInc <= 1'b0;
            SSPTXD      <= 1'b0;
            SSPFSSOUT   <= 1'b1;
            RxData      <= '0;
            RxWrEn      <= 1'b0;
            TxRxBSY     <= 1'b0;
            sck_ph      <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bitcnt      <= '0;
            n_q         <= '0;
            clkdiv_q    <= '0;
        end else begin
            TxFRdPtrInc <= 1'b0;
            RxWrEn      <= 1'b0;
            if (lead_first) rx_sr <= rx_next;
            case (state_q)
                IDLE: begin
                    sck_ph <= 1'b0;
                    if (start) begin
                        tx_sr       <= TxData[DW-2:0];
                        SSPTXD      <= TxData[DW-1];
                        TxFRdPtrInc <= 1'b1;
                        SSPFSSOUT   <= 1'b0;
                        TxRxBSY     <= 1'b1;
                        rx_sr       <= '0;
                        bitcnt      <= '0;
                        n_q         <= effective_bits(DSS);
                        clkdiv_q    <= ClkDiv;
                    end else begin
                        SSPFSSOUT <= 1'b1;
                        TxRxBSY   <= 1'b0;
                    end
                end
                SETUP: if (tc) sck_ph <= 1'b1;
                LEAD: begin
                    if (tc) begin
                        sck_ph <= 1'b0;
                        tx_sr  <= {tx_sr[DW-3:0], 1'b0};
                        SSPTXD <= last_bit ? 1'b0 : tx_sr[DW-2];
                        // rx_next already holds the Nth sample when H is 1
                        if (last_bit) begin
                            RxWrEn <= 1'b1;
                            RxData <= rx_next;
                        end
                    end
                end
                TRAIL: begin
                    if (tc) begin
                        if (!last_bit) begin
                            bitcnt <= bitcnt + BCW'(1);
                            sck_ph <= 1'b1;
                        end else begin
                            SSPFSSOUT <= 1'b1;
                            TxRxBSY   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer with hand-computed frame expectations.
module tb_ssp_tx_serializer;

    localparam int DW = 16;

    logic          SSPCLK = 1'b0;
    logic          SSPRST, SSE, SPO;
    logic [3:0]    DSS;
    logic [7:0]    ClkDiv;
    logic          TxDataAvlbl;
    logic [DW-1:0] TxData;
    logic          SSPRXD, rxd_drv, loopback;
    logic          TxFRdPtrInc, SSPCLKOUT, SSPTXD, SSPFSSOUT, RxWrEn, TxRxBSY;
    logic [DW-1:0] RxData;

    int tests = 0;
    int fails = 0;

    assign SSPRXD = loopback ? SSPTXD : rxd_drv;

    ssp_tx_serializer dut (
        .SSPCLK(SSPCLK), .SSPRST(SSPRST), .SSE(SSE), .SPO(SPO), .DSS(DSS),
        .ClkDiv(ClkDiv), .TxDataAvlbl(TxDataAvlbl), .TxData(TxData),
        .SSPRXD(SSPRXD), .TxFRdPtrInc(TxFRdPtrInc), .SSPCLKOUT(SSPCLKOUT),
        .SSPTXD(SSPTXD), .SSPFSSOUT(SSPFSSOUT), .RxData(RxData),
        .RxWrEn(RxWrEn), .TxRxBSY(TxRxBSY)
    );

    always #5 SSPCLK = ~SSPCLK;

    // Waveform monitor, sampled on the inactive edge; cleared while mon_en is low.
    logic          mon_en = 1'b0;
    int            cyc, n_rdptr, n_rxwr, n_lead, nruns, ngaps, run, hi_run;
    int            fall_cyc, first_lead;
    int            rdptr_t[8];
    int            runs[8];
    int            gaps[8];
    logic [DW-1:0] rx_vals[8];
    logic [31:0]   tx_log;
    logic          prev_fss, prev_sck, seen_low;

    always @(negedge SSPCLK) begin
        if (!mon_en) begin
            cyc = 0; n_rdptr = 0; n_rxwr = 0; n_lead = 0; nruns = 0; ngaps = 0;
            run = 0; hi_run = 0; fall_cyc = -1; first_lead = -1; tx_log = '0;
            prev_fss = 1'b1; prev_sck = SPO; seen_low = 1'b0;
        end else begin
            cyc++;
            if (TxFRdPtrInc === 1'b1) begin
                if (n_rdptr < 8) rdptr_t[n_rdptr] = cyc;
                n_rdptr++;
            end
            if (RxWrEn === 1'b1) begin
                if (n_rxwr < 8) rx_vals[n_rxwr] = RxData;
                n_rxwr++;
            end
            if (SSPCLKOUT !== prev_sck && SSPCLKOUT !== SPO) begin
                n_lead++;
                tx_log = {tx_log[30:0], SSPTXD};
                if (first_lead < 0) first_lead = cyc;
            end
            prev_sck = SSPCLKOUT;
            if (SSPFSSOUT === 1'b0) begin
                if (prev_fss) begin
                    if (seen_low) begin
                        if (ngaps < 8) gaps[ngaps] = hi_run;
                        ngaps++;
                    end
                    if (fall_cyc < 0) fall_cyc = cyc;
                    run = 0;
                end
                run++;
            end else begin
                if (!prev_fss) begin
                    if (nruns < 8) runs[nruns] = run;
                    nruns++;
                    seen_low = 1'b1;
                    hi_run = 0;
                end
                hi_run++;
            end
            prev_fss = SSPFSSOUT;
        end
    end

    task automatic mon_restart();
        mon_en = 1'b0;
        @(negedge SSPCLK);
        @(negedge SSPCLK);
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        SSPRST = 1'b1; SSE = 1'b0; SPO = 1'b1; DSS = 4'd7; ClkDiv = 8'd0;
        TxDataAvlbl = 1'b0; TxData = '0; rxd_drv = 1'b0; loopback = 1'b1;
        #12;
        tests++; if (SSPCLKOUT !== 1'b1) begin fails++; $display("FAIL reset_sck_spo1 got %b want 1", SSPCLKOUT); end
        SPO = 1'b0;
        #1;
        tests++; if (SSPCLKOUT !== 1'b0) begin fails++; $display("FAIL reset_sck_spo0 got %b want 0", SSPCLKOUT); end
        tests++; if (TxFRdPtrInc !== 1'b0) begin fails++; $display("FAIL reset_rdptr got %b want 0", TxFRdPtrInc); end
        tests++; if (SSPTXD !== 1'b0) begin fails++; $display("FAIL reset_txd got %b want 0", SSPTXD); end
        tests++; if (SSPFSSOUT !== 1'b1) begin fails++; $display("FAIL reset_fss got %b want 1", SSPFSSOUT); end
        tests++; if (RxData !== 16'h0000) begin fails++; $display("FAIL reset_rxdata got %h want 0000", RxData); end
        tests++; if (RxWrEn !== 1'b0) begin fails++; $display("FAIL reset_rxwren got %b want 0", RxWrEn); end
        tests++; if (TxRxBSY !== 1'b0) begin fails++; $display("FAIL reset_bsy got %b want 0", TxRxBSY); end
        @(negedge SSPCLK);
        SSPRST = 1'b0;
        SSE = 1'b1;
    endtask

    task automatic test_single_8bit();
        SPO = 1'b0; ClkDiv = 8'd0; DSS = 4'd7; TxData = 16'hA500;
        mon_restart();
        TxDataAvlbl = 1'b1;
        @(negedge SSPCLK);
        TxDataAvlbl = 1'b0;
        repeat (24) @(negedge SSPCLK);
        tests++; if (n_rdptr !== 1) begin fails++; $display("FAIL t1_rdptr_pulses got %0d want 1", n_rdptr); end
        tests++; if (nruns !== 1 || runs[0] !== 17) begin fails++; $display("FAIL t1_fss_low got %0d runs, len %0d want 1, 17", nruns, runs[0]); end
        tests++; if (n_lead !== 8) begin fails++; $display("FAIL t1_sck_edges got %0d want 8", n_lead); end
        tests++; if (tx_log[7:0] !== 8'hA5) begin fails++; $display("FAIL t1_txd_bits got %h want a5", tx_log[7:0]); end
        tests++; if (n_rxwr !== 1 || rx_vals[0] !== 16'h00A5) begin fails++; $display("FAIL t1_rx got %0d strobes, %h want 1, 00a5", n_rxwr, rx_vals[0]); end
    endtask

    task automatic test_slow_16bit();
        SPO = 1'b1; ClkDiv = 8'd3; DSS = 4'd15; TxData = 16'h8001;
        mon_restart();
        tests++; if (SSPCLKOUT !== 1'b1) begin fails++; $display("FAIL t2_sck_idle got %b want 1", SSPCLKOUT); end
        TxDataAvlbl = 1'b1;
        @(negedge SSPCLK);
        TxDataAvlbl = 1'b0;
        repeat (140) @(negedge SSPCLK);
        tests++; if (nruns !== 1 || runs[0] !== 132) begin fails++; $display("FAIL t2_fss_low got %0d runs, len %0d want 1, 132", nruns, runs[0]); end
        tests++; if (first_lead - fall_cyc !== 4) begin fails++; $display("FAIL t2_setup_len got %0d want 4", first_lead - fall_cyc); end
        tests++; if (n_lead !== 16 || tx_log[15:0] !== 16'h8001) begin fails++; $display("FAIL t2_txd_bits got %0d edges, %h want 16, 8001", n_lead, tx_log[15:0]); end
        tests++; if (n_rxwr !== 1 || rx_vals[0] !== 16'h8001) begin fails++; $display("FAIL t2_rx got %0d strobes, %h want 1, 8001", n_rxwr, rx_vals[0]); end
        SPO = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [3];
        int idx;
        words[0] = 16'hA000; words[1] = 16'h5000; words[2] = 16'hC000;
        idx = 0;
        ClkDiv = 8'd0; DSS = 4'd3; TxData = words[0];
        mon_restart();
        TxDataAvlbl = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge SSPCLK);
            if (TxFRdPtrInc === 1'b1) begin
                idx++;
                TxDataAvlbl = (idx < 3);
                TxData = (idx < 3) ? words[idx] : '0;
            end
        end
        tests++; if (n_rdptr !== 3) begin fails++; $display("FAIL t3_rdptr_pulses got %0d want 3", n_rdptr); end
        tests++; if (rdptr_t[1] - rdptr_t[0] !== 10 || rdptr_t[2] - rdptr_t[1] !== 10) begin fails++; $display("FAIL t3_rdptr_spacing got %0d,%0d want 10,10", rdptr_t[1] - rdptr_t[0], rdptr_t[2] - rdptr_t[1]); end
        tests++; if (ngaps !== 2 || gaps[0] !== 1 || gaps[1] !== 1) begin fails++; $display("FAIL t3_fss_gap got %0d gaps %0d,%0d want 2 gaps 1,1", ngaps, gaps[0], gaps[1]); end
        tests++; if (nruns !== 3 || runs[2] !== 9) begin fails++; $display("FAIL t3_fss_low got %0d runs, last %0d want 3, 9", nruns, runs[2]); end
        tests++; if (n_rxwr !== 3) begin fails++; $display("FAIL t3_rx_count got %0d want 3", n_rxwr); end
        tests++; if (rx_vals[0] !== 16'h000A || rx_vals[1] !== 16'h0005 || rx_vals[2] !== 16'h000C) begin fails++; $display("FAIL t3_rx_data got %h %h %h want 000a 0005 000c", rx_vals[0], rx_vals[1], rx_vals[2]); end
    endtask

    task automatic test_dss_clamp();
        logic [DW-1:0] words [2];
        int idx;
        words[0] = 16'h9000; words[1] = 16'h3C00;
        idx = 0;
        ClkDiv = 8'd0; DSS = 4'd1; TxData = words[0];
        mon_restart();
        TxDataAvlbl = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge SSPCLK);
            if (i == 2) DSS = 4'd7;
            if (TxFRdPtrInc === 1'b1) begin
                idx++;
                TxDataAvlbl = (idx < 2);
                TxData = (idx < 2) ? words[idx] : '0;
            end
        end
        tests++; if (nruns !== 2 || runs[0] !== 9) begin fails++; $display("FAIL t4_clamped_len got %0d runs, len %0d want 2, 9", nruns, runs[0]); end
        tests++; if (runs[1] !== 17) begin fails++; $display("FAIL t4_next_len got %0d want 17", runs[1]); end
        tests++; if (n_rxwr !== 2 || rx_vals[0] !== 16'h0009 || rx_vals[1] !== 16'h003C) begin fails++; $display("FAIL t4_rx got %0d strobes, %h %h want 2, 0009 003c", n_rxwr, rx_vals[0], rx_vals[1]); end
    endtask

    task automatic test_sse_drop();
        ClkDiv = 8'd0; DSS = 4'd7; TxData = 16'h6600;
        mon_restart();
        TxDataAvlbl = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge SSPCLK);
            if (i == 7) SSE = 1'b0;
        end
        tests++; if (n_rdptr !== 1) begin fails++; $display("FAIL t5_rdptr_pulses got %0d want 1", n_rdptr); end
        tests++; if (nruns !== 1 || runs[0] !== 17) begin fails++; $display("FAIL t5_fss_low got %0d runs, len %0d want 1, 17", nruns, runs[0]); end
        tests++; if (n_rxwr !== 1 || rx_vals[0] !== 16'h0066) begin fails++; $display("FAIL t5_rx got %0d strobes, %h want 1, 0066", n_rxwr, rx_vals[0]); end
        tests++; if (SSPFSSOUT !== 1'b1 || TxRxBSY !== 1'b0) begin fails++; $display("FAIL t5_idle got fss %b bsy %b want 1 0", SSPFSSOUT, TxRxBSY); end
        TxDataAvlbl = 1'b0;
        @(negedge SSPCLK);
        SSE = 1'b1;
    endtask

    task automatic test_reset_midframe();
        ClkDiv = 8'd1; DSS = 4'd7; TxData = 16'hFF00;
        mon_restart();
        TxDataAvlbl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge SSPCLK);
            if (TxFRdPtrInc === 1'b1) TxDataAvlbl = 1'b0;
        end
        tests++; if (SSPCLKOUT !== 1'b1 || SSPFSSOUT !== 1'b0) begin fails++; $display("FAIL t6_in_lead got sck %b fss %b want 1 0", SSPCLKOUT, SSPFSSOUT); end
        SSPRST = 1'b1;
        #1;
        tests++; if (SSPFSSOUT !== 1'b1 || SSPCLKOUT !== 1'b0 || TxRxBSY !== 1'b0) begin fails++; $display("FAIL t6_abort got fss %b sck %b bsy %b want 1 0 0", SSPFSSOUT, SSPCLKOUT, TxRxBSY); end
        repeat (2) @(negedge SSPCLK);
        SSPRST = 1'b0;
        repeat (3) @(negedge SSPCLK);
        tests++; if (n_rxwr !== 0 || n_rdptr !== 1) begin fails++; $display("FAIL t6_no_rx got %0d strobes %0d pulses want 0, 1", n_rxwr, n_rdptr); end
        TxData = 16'h5A00;
        mon_restart();
        TxDataAvlbl = 1'b1;
        @(negedge SSPCLK);
        TxDataAvlbl = 1'b0;
        repeat (44) @(negedge SSPCLK);
        tests++; if (n_rdptr !== 1) begin fails++; $display("FAIL t6_reload got %0d pulses want 1", n_rdptr); end
        tests++; if (nruns !== 1 || runs[0] !== 34) begin fails++; $display("FAIL t6_fss_low got %0d runs, len %0d want 1, 34", nruns, runs[0]); end
        tests++; if (n_rxwr !== 1 || rx_vals[0] !== 16'h005A) begin fails++; $display("FAIL t6_rx got %0d strobes, %h want 1, 005a", n_rxwr, rx_vals[0]); end
    endtask

    initial begin
        test_reset();
        test_single_8bit();
        test_slow_16bit();
        test_back_to_back();
        test_dss_clamp();
        test_sse_drop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
